vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Raster timing generator for the 640x480 display path. It divides the system clock down to a pixel rate and walks horizontal and vertical counters through active, front-porch, sync and back-porch segments. It drives `x`, `y`, `video_on`, `hsync` and `vsync`, which the pixel generator consumes. `x` and `y` keep counting through blanking, so downstream logic can decode retrace positions.

## Interface
- `H_ACTIVE`, default 640: visible pixels per line
- `H_FRONT`, default 16: horizontal front porch, in pixels
- `H_SYNC`, default 96: hsync width, in pixels
- `H_BACK`, default 48: horizontal back porch, in pixels
- `V_ACTIVE`, default 480: visible lines
- `V_FRONT`, default 10: vertical front porch, in lines
- `V_SYNC`, default 2: vsync width, in lines
- `V_BACK`, default 33: vertical back porch, in lines
- `CLK_DIV`, default 2: clk cycles per pixel; must be ≥ 1
- `HSYNC_POL`, default 0: asserted level of hsync (0 = active-low)
- `VSYNC_POL`, default 0: asserted level of vsync
- `X_BIT_WIDTH`, default 10: width of `x`; must hold H_TOTAL-1
- `Y_BIT_WIDTH`, default 10: width of `y`; must hold V_TOTAL-1

Ports:
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-high
- `pixel_tick` out 1: one-clk pulse marking the first clk of each new pixel
- `x` out X_BIT_WIDTH: horizontal position, 0..H_TOTAL-1
- `y` out Y_BIT_WIDTH: vertical position, 0..V_TOTAL-1
- `video_on` out 1: position is inside the active area
- `hsync` out 1: horizontal sync at HSYNC_POL level when asserted
- `vsync` out 1: vertical sync at VSYNC_POL level when asserted
- `line_start` out 1: pulse with `pixel_tick` when the new x is 0
- `frame_start` out 1: pulse with `pixel_tick` when the new position is (0,0)
- `vblank_start` out 1: pulse with `pixel_tick` when the new position is (0,V_ACTIVE)

## Operation
- Totals: H_TOTAL = sum of the four H segments (800); V_TOTAL = sum of the four V segments (525).
- Divider: `div_cnt` counts 0..CLK_DIV-1. An advance edge is any clk edge where `div_cnt` equals CLK_DIV-1. On that edge `div_cnt` returns to 0.
- Horizontal axis: an FSM with states ACTIVE → FRONT → SYNC → BACK → ACTIVE, plus a segment counter.
  - A state ends when its segment counter reaches its length minus 1.
  - `x` increments on every advance edge and wraps from H_TOTAL-1 to 0.
- Vertical axis: the same FSM, but it steps only on an advance edge where `x` wraps. `y` wraps from V_TOTAL-1 to 0.
- `hsync` is asserted for x = H_ACTIVE+H_FRONT .. H_ACTIVE+H_FRONT+H_SYNC-1, which is 656..751 with defaults. Otherwise it holds the inverse of HSYNC_POL.
- `vsync` is asserted for y = 490..491 with defaults; it follows the same rule.
- `video_on` = horizontal ACTIVE AND vertical ACTIVE, which is x < 640 and y < 480.
- All outputs are registered and coherent: `x`, `y`, `video_on`, `hsync` and `vsync` always describe the same pixel. Each value is held for exactly CLK_DIV clks.
- Reset values:
  - `x` = H_TOTAL-1 and `y` = V_TOTAL-1 (the last back-porch pixel)
  - horizontal and vertical FSMs in BACK
  - `div_cnt` = 0
  - `video_on` = 0
  - `hsync` = ~HSYNC_POL and `vsync` = ~VSYNC_POL
  - all pulse outputs = 0
- Consequence of the reset values: the first advance lands on (0,0) and asserts `frame_start`.

## Timing
- Reset release to first (0,0): CLK_DIV clk edges. `pixel_tick`, `line_start` and `frame_start` are high in the clk following that edge.
- CLK_DIV = 1: `pixel_tick` is constantly 1 after the first edge, and a new position appears every clk.
- Pulse outputs are exactly one clk wide, regardless of CLK_DIV.
- An x wrap and a y wrap on the same edge give (0,0), `frame_start`, `line_start` and `vblank_start`=0, all in one step.
- Asserting reset mid-frame forces the reset values immediately (asynchronously). Deassertion restarts at the frame origin as above; there is no partial-frame state.
- Line period = H_TOTAL×CLK_DIV clks. Frame period = H_TOTAL×V_TOTAL×CLK_DIV clks (840000 with defaults).

## Structure
- Package `vga_timing_pkg` holds:
  - the default 640x480 segment constants
  - the derived H_TOTAL and V_TOTAL
  - the axis state typedef (ACTIVE, FRONT, SYNC, BACK)
- Sub-module `vga_axis_counter` is instantiated twice, once per axis.
  - Parameters: ACTIVE, FRONT, SYNC and BACK lengths, plus width.
  - Inputs: `step`.
  - Outputs: `pos`, `state`, `wrap`.
- The top level contains the divider, sync-polarity application, pulse generation and output registers.

## Test plan
- Reset release with defaults → `x`=799, `y`=524, `video_on`=0, `hsync`=`vsync`=1. Two clks later: (0,0), `video_on`=1, `frame_start`=1 for one clk.
- Free-run one line → `hsync` low for exactly 96 ticks starting at x=656, `video_on` high for 640 ticks, `line_start` every 1600 clks.
- Free-run one frame → `vsync` low during y=490–491 only. `video_on` is high for 307200 ticks, `vblank_start` is seen once at (0,480), and `frame_start` recurs after 840000 clks.
- CLK_DIV=1, HSYNC_POL=VSYNC_POL=1 → x advances every clk, `hsync` is high at x=656..751, and `vsync` is high at y=490..491.
- Reset pulse at (300,200) → outputs return to reset values in the same cycle. After release, the next position is (0,0) with `frame_start`.
- Check on every clk → `video_on` == (x<640 && y<480), and `x`/`y` never exceed 799/524.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the 640x480 raster timing generator.
package vga_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FRONT  = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BACK   = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FRONT  = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BACK   = 33;
    localparam int unsigned DEF_CLK_DIV  = 2;

    localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_FRONT,
        ST_SYNC,
        ST_BACK
    } axis_state_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK segment FSM.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE_LEN = DEF_H_ACTIVE,
    parameter int unsigned FRONT_LEN  = DEF_H_FRONT,
    parameter int unsigned SYNC_LEN   = DEF_H_SYNC,
    parameter int unsigned BACK_LEN   = DEF_H_BACK,
    parameter int unsigned WIDTH      = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    output logic [WIDTH-1:0] pos,
    output axis_state_t      state,
    output axis_state_t      next_state,
    output logic             wrap
);

    localparam int unsigned      TOTAL    = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;
    localparam logic [WIDTH-1:0] POS_LAST = WIDTH'(TOTAL - 1);

    logic [WIDTH-1:0] seg_cnt;
    logic [WIDTH-1:0] seg_cnt_nxt;
    logic [WIDTH-1:0] seg_last;
    logic [WIDTH-1:0] pos_nxt;

    always_comb begin
        seg_last = WIDTH'(BACK_LEN - 1);
        case (state)
            ST_ACTIVE: seg_last = WIDTH'(ACTIVE_LEN - 1);
            ST_FRONT:  seg_last = WIDTH'(FRONT_LEN - 1);
            ST_SYNC:   seg_last = WIDTH'(SYNC_LEN - 1);
            ST_BACK:   seg_last = WIDTH'(BACK_LEN - 1);
            default:   seg_last = WIDTH'(BACK_LEN - 1);
        endcase
    end

    always_comb begin
        wrap        = step && (pos == POS_LAST);
        pos_nxt     = pos;
        seg_cnt_nxt = seg_cnt;
        next_state  = state;
        if (step) begin
            pos_nxt = wrap ? '0 : pos + 1'b1;
            if (seg_cnt == seg_last) begin
                seg_cnt_nxt = '0;
                case (state)
                    ST_ACTIVE: next_state = ST_FRONT;
                    ST_FRONT:  next_state = ST_SYNC;
                    ST_SYNC:   next_state = ST_BACK;
                    default:   next_state = ST_ACTIVE;
                endcase
            end else begin
                seg_cnt_nxt = seg_cnt + 1'b1;
            end
        end
    end

    // Reset parks on the last back-porch position so the first step lands on 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos     <= POS_LAST;
            state   <= ST_BACK;
            seg_cnt <= WIDTH'(BACK_LEN - 1);
        end else begin
            pos     <= pos_nxt;
            state   <= next_state;
            seg_cnt <= seg_cnt_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-rate divider, two axis counters and
// registered sync/blank/pulse outputs that always describe the same pixel.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT     = DEF_H_FRONT,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BACK      = DEF_H_BACK,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT     = DEF_V_FRONT,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BACK      = DEF_V_BACK,
    parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
    parameter logic        HSYNC_POL   = 1'b0,
    parameter logic        VSYNC_POL   = 1'b0,
    parameter int unsigned X_BIT_WIDTH = 10,
    parameter int unsigned Y_BIT_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   pixel_tick,
    output logic [X_BIT_WIDTH-1:0] x,
    output logic [Y_BIT_WIDTH-1:0] y,
    output logic                   video_on,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   line_start,
    output logic                   frame_start,
    output logic                   vblank_start
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             advance;
    logic             h_wrap;
    logic             v_wrap;
    axis_state_t      h_state;
    axis_state_t      h_next;
    axis_state_t      v_state;
    axis_state_t      v_next;

    assign advance = (div_cnt == DIV_LAST);

    vga_axis_counter #(
        .ACTIVE_LEN (H_ACTIVE),
        .FRONT_LEN  (H_FRONT),
        .SYNC_LEN   (H_SYNC),
        .BACK_LEN   (H_BACK),
        .WIDTH      (X_BIT_WIDTH)
    ) u_h_axis (
        .clk        (clk),
        .reset      (reset),
        .step       (advance),
        .pos        (x),
        .state      (h_state),
        .next_state (h_next),
        .wrap       (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE_LEN (V_ACTIVE),
        .FRONT_LEN  (V_FRONT),
        .SYNC_LEN   (V_SYNC),
        .BACK_LEN   (V_BACK),
        .WIDTH      (Y_BIT_WIDTH)
    ) u_v_axis (
        .clk        (clk),
        .reset      (reset),
        .step       (h_wrap),
        .pos        (y),
        .state      (v_state),
        .next_state (v_next),
        .wrap       (v_wrap)
    );

    // Levels are decoded from the axis next-states so they register on the
    // same edge as the new x/y and stay coherent with them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt      <= '0;
            pixel_tick   <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            video_on     <= 1'b0;
            hsync        <= ~HSYNC_POL;
            vsync        <= ~VSYNC_POL;
        end else begin
            div_cnt      <= advance ? '0 : div_cnt + 1'b1;
            pixel_tick   <= advance;
            line_start   <= advance && (h_state == ST_BACK) && (h_next == ST_ACTIVE);
            frame_start  <= v_wrap;
            vblank_start <= h_wrap && (v_state == ST_ACTIVE) && (v_next == ST_FRONT);
            if (advance) begin
                video_on <= (h_next == ST_ACTIVE) && (v_next == ST_ACTIVE);
                hsync    <= (h_next == ST_SYNC) ? HSYNC_POL : ~HSYNC_POL;
                vsync    <= (v_next == ST_SYNC) ? VSYNC_POL : ~VSYNC_POL;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: default geometry plus a small
// CLK_DIV=1, positive-polarity instance that can run whole frames quickly.
module tb_vga_timing_gen;

    localparam int A_HA = 640, A_HF = 16, A_HS = 96, A_VA = 480, A_VF = 10, A_VS = 2;
    localparam int A_HT = 800, A_VT = 525, A_DIV = 2;
    localparam int B_HA = 8, B_HF = 2, B_HS = 3, B_HB = 2;
    localparam int B_VA = 6, B_VF = 2, B_VS = 2, B_VB = 3;
    localparam int B_HT = 15, B_VT = 13, B_DIV = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_pt, a_vo, a_hs, a_vs, a_ls, a_fs, a_vb;
    logic [9:0] a_x, a_y;
    logic       b_pt, b_vo, b_hs, b_vs, b_ls, b_fs, b_vb;
    logic [3:0] b_x, b_y;

    always #5 clk = ~clk;

    vga_timing_gen u_dut_a (
        .clk(clk), .reset(reset), .pixel_tick(a_pt), .x(a_x), .y(a_y),
        .video_on(a_vo), .hsync(a_hs), .vsync(a_vs), .line_start(a_ls),
        .frame_start(a_fs), .vblank_start(a_vb)
    );

    vga_timing_gen #(
        .H_ACTIVE(B_HA), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
        .V_ACTIVE(B_VA), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
        .CLK_DIV(B_DIV), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
        .X_BIT_WIDTH(4), .Y_BIT_WIDTH(4)
    ) u_dut_b (
        .clk(clk), .reset(reset), .pixel_tick(b_pt), .x(b_x), .y(b_y),
        .video_on(b_vo), .hsync(b_hs), .vsync(b_vs), .line_start(b_ls),
        .frame_start(b_fs), .vblank_start(b_vb)
    );

    typedef struct { int div; int x; int y; } mstate_t;
    typedef struct { int x; int y; int flags; } exp_t;

    exp_t    qa[$];
    exp_t    qb[$];
    mstate_t sa, sb;
    int      tests_run = 0;
    int      tests_failed = 0;
    int      cyc = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pack_flags(input bit vo, hs, vs, pt, ls, fs, vb);
        return int'({vo, hs, vs, pt, ls, fs, vb});
    endfunction

    function automatic exp_t expect_out(input mstate_t s, input int ha, hf, hsw, va, vf, vsw,
                                        input bit hp, vp, pt, ls, fs, vb);
        bit vo, hs, vs;
        exp_t e;
        vo = (s.x < ha) && (s.y < va);
        hs = (s.x >= ha + hf && s.x < ha + hf + hsw) ? hp : !hp;
        vs = (s.y >= va + vf && s.y < va + vf + vsw) ? vp : !vp;
        e.x = s.x;
        e.y = s.y;
        e.flags = pack_flags(vo, hs, vs, pt, ls, fs, vb);
        return e;
    endfunction

    task automatic model_step(inout mstate_t s, input int div, ht, vt, va,
                              output bit pt, ls, fs, vb);
        pt = (s.div == div - 1);
        s.div = pt ? 0 : s.div + 1;
        ls = 0; fs = 0; vb = 0;
        if (pt) begin
            s.x = s.x + 1;
            if (s.x == ht) begin
                s.x = 0;
                s.y = (s.y + 1 == vt) ? 0 : s.y + 1;
                ls = 1;
                fs = (s.y == 0);
                vb = (s.y == va);
            end
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk or posedge reset) begin : model_a
        bit pt, ls, fs, vb;
        if (reset) begin
            sa.div = 0; sa.x = A_HT - 1; sa.y = A_VT - 1;
            qa.delete();
            qa.push_back(expect_out(sa, A_HA, A_HF, A_HS, A_VA, A_VF, A_VS, 0, 0, 0, 0, 0, 0));
        end else begin
            model_step(sa, A_DIV, A_HT, A_VT, A_VA, pt, ls, fs, vb);
            qa.push_back(expect_out(sa, A_HA, A_HF, A_HS, A_VA, A_VF, A_VS, 0, 0, pt, ls, fs, vb));
        end
    end

    always @(posedge clk or posedge reset) begin : model_b
        bit pt, ls, fs, vb;
        if (reset) begin
            sb.div = 0; sb.x = B_HT - 1; sb.y = B_VT - 1;
            qb.delete();
            qb.push_back(expect_out(sb, B_HA, B_HF, B_HS, B_VA, B_VF, B_VS, 1, 1, 0, 0, 0, 0));
        end else begin
            model_step(sb, B_DIV, B_HT, B_VT, B_VA, pt, ls, fs, vb);
            qb.push_back(expect_out(sb, B_HA, B_HF, B_HS, B_VA, B_VF, B_VS, 1, 1, pt, ls, fs, vb));
        end
    end

    always @(negedge clk) begin : scoreboard
        exp_t e;
        while (qa.size() > 0) begin
            e = qa.pop_front();
            check_val("a_x", int'(a_x), e.x);
            check_val("a_y", int'(a_y), e.y);
            check_val("a_flags", pack_flags(a_vo, a_hs, a_vs, a_pt, a_ls, a_fs, a_vb), e.flags);
        end
        while (qb.size() > 0) begin
            e = qb.pop_front();
            check_val("b_x", int'(b_x), e.x);
            check_val("b_y", int'(b_y), e.y);
            check_val("b_flags", pack_flags(b_vo, b_hs, b_vs, b_pt, b_ls, b_fs, b_vb), e.flags);
        end
    end

    // Aggregate line/frame measurements, independent of the per-clk model.
    bit mon_en = 0;
    int a_vo_ticks = 0, a_hs_ticks = 0, a_hs_first = -1, a_last_ls = -1, a_period = -1;
    int b_fs_cnt = 0, b_first_fs = 0, b_period = -1, b_vo_ticks = 0, b_vb_cnt = 0, b_vs_ticks = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (a_pt && a_y == 0) begin
                if (a_vo) a_vo_ticks++;
                if (!a_hs) begin
                    if (a_hs_ticks == 0) a_hs_first = int'(a_x);
                    a_hs_ticks++;
                end
            end
            if (a_ls) begin
                if (a_last_ls >= 0) a_period = cyc - a_last_ls;
                a_last_ls = cyc;
            end
            if (b_fs) begin
                if (b_fs_cnt == 0) b_first_fs = cyc;
                if (b_fs_cnt == 1) b_period = cyc - b_first_fs;
                b_fs_cnt++;
            end
            if (b_fs_cnt == 1 && b_pt) begin
                if (b_vo) b_vo_ticks++;
                if (b_vb) b_vb_cnt++;
                if (b_vs) b_vs_ticks++;
            end
        end
    end

    initial begin
        bit found;
        repeat (3) @(negedge clk);
        check_val("rst_a_x", int'(a_x), 799);
        check_val("rst_a_y", int'(a_y), 524);
        check_val("rst_a_flags", pack_flags(a_vo, a_hs, a_vs, a_pt, a_ls, a_fs, a_vb),
                  pack_flags(0, 1, 1, 0, 0, 0, 0));

        #1 reset = 1'b0;
        mon_en = 1;
        @(negedge clk);
        check_val("rel1_a_x", int'(a_x), 799);
        check_val("rel1_a_tick", int'(a_pt), 0);
        check_val("rel1_b_fs", int'(b_fs), 1);
        @(negedge clk);
        check_val("rel2_a_xy", int'({a_x, a_y}), 0);
        check_val("rel2_a_flags", pack_flags(a_vo, a_hs, a_vs, a_pt, a_ls, a_fs, a_vb),
                  pack_flags(1, 1, 1, 1, 1, 1, 0));
        @(negedge clk);
        check_val("rel3_a_fs_width", int'(a_fs), 0);
        check_val("rel3_a_x_held", int'(a_x), 0);

        repeat (4900) @(negedge clk);
        mon_en = 0;
        check_val("a_vo_ticks_line", a_vo_ticks, 640);
        check_val("a_hs_ticks_line", a_hs_ticks, 96);
        check_val("a_hs_first_x", a_hs_first, 656);
        check_val("a_line_period", a_period, 1600);
        check_val("b_frame_period", b_period, B_HT * B_VT);
        check_val("b_vo_ticks_frame", b_vo_ticks, B_HA * B_VA);
        check_val("b_vblank_count", b_vb_cnt, 1);
        check_val("b_vs_ticks_frame", b_vs_ticks, B_VS * B_HT);

        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (b_x == 4'd5 && b_y == 4'd7) found = 1;
        end
        check_val("b_reach_5_7", int'(found), 1);
        #1 reset = 1'b1;
        #1;
        check_val("mid_a_xy", int'({a_x, a_y}), (799 << 10) | 524);
        check_val("mid_a_flags", pack_flags(a_vo, a_hs, a_vs, a_pt, a_ls, a_fs, a_vb),
                  pack_flags(0, 1, 1, 0, 0, 0, 0));
        check_val("mid_b_xy", int'({b_x, b_y}), (14 << 4) | 12);
        check_val("mid_b_flags", pack_flags(b_vo, b_hs, b_vs, b_pt, b_ls, b_fs, b_vb), 0);

        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_val("mid_rel_b_xy", int'({b_x, b_y}), 0);
        check_val("mid_rel_b_fs", int'(b_fs), 1);
        check_val("mid_rel_a_tick", int'(a_pt), 0);
        @(negedge clk);
        check_val("mid_rel_a_xy", int'({a_x, a_y}), 0);
        check_val("mid_rel_a_fs", int'(a_fs), 1);
        check_val("mid_rel_b_fs_width", int'(b_fs), 0);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
